// File: rtl/data_mem_arbiter_pkg.sv
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               These are the FSM state encoding, the bus widths and the
//               saturating wait-counter increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_arbiter_pkg;

  localparam int DM_ADDR_W = 4;
  localparam int DM_DATA_W = 4;
  localparam int DM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_arb_state_t;

  // Host wait counter stops at all-ones instead of wrapping.
  function automatic logic [DM_CNT_W-1:0] sat_inc(input logic [DM_CNT_W-1:0] v);
    return (v == '1) ? v : v + DM_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : Bundles the core, host and data_memory signals of the arbiter.
//               slave  : arbiter side (drives core_rdata/stall, host_*
//                        responses and mem_addr/data/wren).
//               master : environment side (core, host and memory q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_arbiter_if;
  import data_mem_arbiter_pkg::*;

  // core side
  logic                 core_req;
  logic [DM_ADDR_W-1:0] core_addr;
  logic [DM_DATA_W-1:0] core_wdata;
  logic                 core_wren;
  logic [DM_DATA_W-1:0] core_rdata;
  logic                 core_stall;
  // host / debug side
  logic                 host_req;
  logic                 host_we;
  logic [DM_ADDR_W-1:0] host_addr;
  logic [DM_DATA_W-1:0] host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [DM_DATA_W-1:0] host_rdata;
  // data_memory side
  logic [DM_ADDR_W-1:0] mem_addr;
  logic [DM_DATA_W-1:0] mem_data;
  logic                 mem_wren;
  logic [DM_DATA_W-1:0] mem_q;

  modport slave (
    input  core_req, core_addr, core_wdata, core_wren,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_q,
    output core_rdata, core_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output core_req, core_addr, core_wdata, core_wren,
    output host_req, host_we, host_addr, host_wdata,
    output mem_q,
    input  core_rdata, core_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares the 16x4 data memory between the micro core and a
//               host/debug port. The core has priority. The host is granted
//               in cycles where the core does not touch memory.
//               Ports : clk, reset (async, active-high),
//                       bus (data_mem_arbiter_if.slave: core, host, memory).
//               Param : MAX_WAIT (1..15). This is the number of host wait
//                       cycles before the starvation guard stalls the core.
//               Macro : DM_ARB_STARVE_GUARD_EN. When it is defined, the core
//                       is stalled for one cycle after MAX_WAIT blocked host
//                       cycles. When it is undefined, core priority is strict
//                       and core_stall is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_arbiter_if.slave   bus
);

  localparam logic [DM_CNT_W-1:0] c_GUARD_CNT = DM_CNT_W'(MAX_WAIT - 1);

  dm_arb_state_t        r_state;
  dm_arb_state_t        w_state_nxt;
  logic [DM_CNT_W-1:0]  r_wait_cnt;
  logic [DM_CNT_W-1:0]  w_wait_cnt_nxt;
  logic [DM_DATA_W-1:0] r_host_rdata;
  logic                 w_host_gnt;
  logic                 w_core_stall;
  logic                 w_guard_en;
  logic                 w_guard_hit;

`ifdef DM_ARB_STARVE_GUARD_EN
  assign w_guard_en = 1'b1;
`else
  assign w_guard_en = 1'b0;
`endif

  assign w_guard_hit = w_guard_en && (r_wait_cnt == c_GUARD_CNT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      // mem_q holds the host address's data by the edge that ends the grant cycle
      if (w_host_gnt && !bus.host_we) begin
        r_host_rdata <= bus.mem_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state, grant and stall
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_host_gnt     = 1'b0;
    w_core_stall   = 1'b0;

    case (r_state)
      // RESP accepts a new request just like IDLE, so grants can run back-to-back.
      IDLE, RESP: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
        if (bus.host_req) begin
          if (!bus.core_req) begin
            w_host_gnt  = 1'b1;
            w_state_nxt = bus.host_we ? IDLE : RESP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        if (!bus.host_req) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else if (!bus.core_req || w_guard_hit) begin
          // The core is either idle or stalled this cycle, so it never sees the host access.
          w_core_stall   = bus.core_req;
          w_host_gnt     = 1'b1;
          w_state_nxt    = bus.host_we ? IDLE : RESP;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = sat_inc(r_wait_cnt);
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory mux and outputs
  // --------------------------------------------------------------------------
  assign bus.mem_addr    = w_host_gnt ? bus.host_addr  : bus.core_addr;
  assign bus.mem_data    = w_host_gnt ? bus.host_wdata : bus.core_wdata;
  assign bus.mem_wren    = w_host_gnt ? bus.host_we    : bus.core_wren;

  assign bus.core_rdata  = bus.mem_q;
  assign bus.core_stall  = w_core_stall;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.host_rvalid = (r_state == RESP);
  assign bus.host_rdata  = r_host_rdata;

endmodule

`default_nettype wire
